// File: rtl/matmul_arbiter.sv
// ============================================================================
// Module      : matmul_arbiter
// Description : Round-robin arbiter that lets two requesters share a single
//               3x3 8-bit matrix multiplier. It registers the winner's
//               operands and waits for the multiplier to finish. The result
//               is captured and returned with a one-cycle rvalid pulse.
//               Optional feature macro: MATMUL_ARB_TIMEOUT_EN adds a RUN-state
//               watchdog with a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [71:0] a0,
  input  logic [71:0] b0,
  input  logic [71:0] a1,
  input  logic [71:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [71:0] c_out,
  output logic        busy,
  output logic        mm_enable,
  output logic [71:0] mm_a,
  output logic [71:0] mm_b,
  input  logic [71:0] mm_c,
  input  logic        mm_done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        last_winner_q, last_winner_d;
  logic        owner_q, owner_d;
  logic [71:0] mm_a_q, mm_a_d;
  logic [71:0] mm_b_q, mm_b_d;
  logic [71:0] c_out_q, c_out_d;
  // Set once mm_done has been seen low in RUN; a done that was already high
  // on entry belongs to a previous job and must not be captured.
  logic        armed_q, armed_d;
  logic        w_winner;

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  // Parameter is only meaningful with the watchdog built in.
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Round-robin pick: on a tie the requester that was not served last wins.
  always_comb begin
    w_winner = 1'b0;
    if (req0 && req1) begin
      w_winner = ~last_winner_q;
    end else begin
      w_winner = req1;
    end
  end

  // Next-state and datapath control for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    owner_d       = owner_q;
    mm_a_d        = mm_a_q;
    mm_b_d        = mm_b_q;
    c_out_d       = c_out_q;
    armed_d       = armed_q;
`ifdef MATMUL_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d       = w_winner;
          last_winner_d = w_winner;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        mm_a_d  = owner_q ? a1 : a0;
        mm_b_d  = owner_q ? b1 : b0;
        armed_d = 1'b0;
`ifdef MATMUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mm_done && armed_q) begin
          c_out_d = mm_c;
          state_d = S_RESP;
        end else begin
          if (!mm_done) begin
            armed_d = 1'b1;
          end
`ifdef MATMUL_ARB_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            c_out_d = '0;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      S_RESP: begin
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        // Wait for the multiplier to drop done so the next job starts clean.
        if (!mm_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      last_winner_q <= 1'b1;
      owner_q       <= 1'b0;
      mm_a_q        <= '0;
      mm_b_q        <= '0;
      c_out_q       <= '0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      owner_q       <= owner_d;
      mm_a_q        <= mm_a_d;
      mm_b_q        <= mm_b_d;
      c_out_q       <= c_out_d;
      armed_q       <= armed_d;
    end
  end

`ifdef MATMUL_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Outputs decode directly from registered state, so reset clears them
  // without waiting for a clock edge.
  assign gnt0      = (state_q == S_GRANT) && !owner_q;
  assign gnt1      = (state_q == S_GRANT) &&  owner_q;
  assign rvalid0   = (state_q == S_RESP)  && !owner_q;
  assign rvalid1   = (state_q == S_RESP)  &&  owner_q;
  assign busy      = (state_q != S_IDLE);
  assign mm_enable = (state_q == S_RUN);
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign c_out     = c_out_q;

endmodule

`default_nettype wire

// File: tb/tb_matmul_arbiter.sv
// ============================================================================
// Module      : tb_matmul_arbiter
// Description : Directed self-checking bench for matmul_arbiter with a
//               behavioural 3-cycle multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_arbiter;

  localparam int LAT = 3;
  localparam int TO  = 16;

  localparam logic [71:0] A0 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] B0 = {8'd1, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
  localparam logic [71:0] E0 = {8'd93, 8'd150, 8'd126, 8'd57, 8'd96, 8'd81, 8'd21, 8'd42, 8'd36};
  localparam logic [71:0] A1 = {8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2};
  localparam logic [71:0] B1 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] E1 = {8'd18, 8'd16, 8'd14, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2};

  logic        Clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [71:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mm_enable, err;
  logic [71:0] c_out, mm_a, mm_b, mm_c;
  logic        mm_done;

  logic        use_manual = 1'b0;
  logic        manual_done = 1'b0;
  logic        mdone = 1'b0;
  int          mcnt = 0;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  matmul_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .c_out(c_out), .busy(busy), .mm_enable(mm_enable),
    .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_done(mm_done), .err(err)
  );

  function automatic logic [71:0] matmul(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] r;
    logic [7:0]  s;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 8'd0;
        for (int k = 0; k < 3; k++) begin
          s = s + 8'(a[(3*i+k)*8 +: 8] * b[(3*k+j)*8 +: 8]);
        end
        r[(3*i+j)*8 +: 8] = s;
      end
    end
    return r;
  endfunction

  // Multiplier model: done rises LAT enabled cycles after enable, falls with enable.
  assign mm_c    = matmul(mm_a, mm_b);
  assign mm_done = use_manual ? manual_done : mdone;
  always @(posedge Clock) begin
    if (!mm_enable) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else if (!mdone) begin
      if (mcnt == LAT - 1) mdone <= 1'b1;
      else mcnt <= mcnt + 1;
    end
  end

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; use_manual = 1'b0; manual_done = 1'b0;
    @(negedge Clock);
    reset = 1'b0;
    repeat (2) @(negedge Clock);
    reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
      failures++; $display("FAIL reset_pulses: got %b want 0000", {gnt0, gnt1, rvalid0, rvalid1});
    end
    checks++;
    if ({busy, mm_enable, err} !== 3'b0) begin
      failures++; $display("FAIL reset_status: got %b want 000", {busy, mm_enable, err});
    end
    checks++;
    if ({c_out, mm_a, mm_b} !== 216'h0) begin
      failures++; $display("FAIL reset_data: got c=%h a=%h b=%h want 0", c_out, mm_a, mm_b);
    end
    repeat (2) @(negedge Clock);
    reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_single();
    int tg = -1, tr = -1, ng = 0, nr = 0, ne = 0, other = 0;
    logic [71:0] cap = '0;
    a0 = A0; b0 = B0; req0 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (gnt0) begin ng++; tg = c; req0 = 1'b0; end
      if (rvalid0) begin nr++; tr = c; cap = c_out; end
      if (mm_enable) ne++;
      if (gnt1 || rvalid1) other++;
    end
    req0 = 1'b0;
    checks++;
    if (ng != 1) begin failures++; $display("FAIL single_gnt_count: got %0d want 1", ng); end
    checks++;
    if (nr != 1) begin failures++; $display("FAIL single_rvalid_count: got %0d want 1", nr); end
    checks++;
    if (cap !== E0) begin failures++; $display("FAIL single_product: got %h want %h", cap, E0); end
    checks++;
    if (tr - tg != LAT + 2) begin failures++; $display("FAIL single_latency: got %0d want %0d", tr - tg, LAT + 2); end
    checks++;
    if (ne != LAT + 1) begin failures++; $display("FAIL single_enable_cycles: got %0d want %0d", ne, LAT + 1); end
    checks++;
    if (other != 0) begin failures++; $display("FAIL single_other_port: got %0d want 0", other); end
    checks++;
    if ({busy, err} !== 2'b00) begin failures++; $display("FAIL single_idle_after: got %b want 00", {busy, err}); end
  endtask

  task automatic test_dual();
    int n = 0, nr0 = 0, nr1 = 0, viol = 0;
    int ord[2];
    logic gap = 1'b0, first_done = 1'b0;
    logic [71:0] c0 = '0, c1 = '0;
    ord[0] = -1; ord[1] = -1;
    do_reset();
    a0 = A0; b0 = B0; a1 = A1; b1 = B1;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) viol++;
      if (first_done && n == 1 && !mm_enable) gap = 1'b1;
      if (gnt0) begin if (n < 2) ord[n] = 0; n++; req0 = 1'b0; end
      if (gnt1) begin if (n < 2) ord[n] = 1; n++; req1 = 1'b0; end
      if (rvalid0) begin nr0++; c0 = c_out; first_done = 1'b1; end
      if (rvalid1) begin nr1++; c1 = c_out; first_done = 1'b1; end
    end
    checks++;
    if (ord[0] != 0 || ord[1] != 1) begin
      failures++; $display("FAIL dual_order: got %0d,%0d want 0,1", ord[0], ord[1]);
    end
    checks++;
    if (nr0 != 1 || nr1 != 1) begin
      failures++; $display("FAIL dual_rvalid_counts: got %0d,%0d want 1,1", nr0, nr1);
    end
    checks++;
    if (c0 !== E0) begin failures++; $display("FAIL dual_product0: got %h want %h", c0, E0); end
    checks++;
    if (c1 !== E1) begin failures++; $display("FAIL dual_product1: got %h want %h", c1, E1); end
    checks++;
    if (gap !== 1'b1) begin failures++; $display("FAIL dual_enable_gap: got %b want 1", gap); end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL dual_onehot: got %0d want 0", viol); end
  endtask

  task automatic test_back_to_back();
    int n = 0, viol = 0;
    int ord[8];
    for (int i = 0; i < 8; i++) ord[i] = -1;
    do_reset();
    a0 = A0; b0 = B0; a1 = A1; b1 = B1;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge Clock);
      if (gnt0 && gnt1) viol++;
      if (gnt0) begin if (n < 8) ord[n] = 0; n++; req0 = 1'b0; end else req0 = 1'b1;
      if (gnt1) begin if (n < 8) ord[n] = 1; n++; req1 = 1'b0; end else req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n < 4) begin failures++; $display("FAIL rr_job_count: got %0d want >=4", n); end
    checks++;
    if (ord[0] != 0 || ord[1] != 1 || ord[2] != 0 || ord[3] != 1) begin
      failures++;
      $display("FAIL rr_order: got %0d,%0d,%0d,%0d want 0,1,0,1", ord[0], ord[1], ord[2], ord[3]);
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL rr_onehot: got %0d want 0", viol); end
  endtask

  task automatic test_stale_done();
    int nr = 0, early = 0, nbusy = 0;
    logic got_gnt = 1'b0;
    logic [71:0] cap = '0;
    do_reset();
    use_manual = 1'b1; manual_done = 1'b1;
    a0 = A0; b0 = B0; req0 = 1'b1;
    for (int c = 0; c < 10 && !got_gnt; c++) begin
      @(negedge Clock);
      if (gnt0) begin got_gnt = 1'b1; req0 = 1'b0; end
    end
    req0 = 1'b0;
    checks++;
    if (!got_gnt) begin failures++; $display("FAIL stale_gnt: got none want gnt0"); end
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      if (rvalid0 || rvalid1) early++;
      if (busy) nbusy++;
    end
    checks++;
    if (early != 0) begin failures++; $display("FAIL stale_no_capture: got %0d rvalids want 0", early); end
    checks++;
    if (nbusy != 6) begin failures++; $display("FAIL stale_busy: got %0d want 6", nbusy); end
    manual_done = 1'b0;
    repeat (2) @(negedge Clock);
    manual_done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      if (rvalid0) begin nr++; cap = c_out; end
    end
    manual_done = 1'b0;
    checks++;
    if (nr != 1) begin failures++; $display("FAIL stale_rvalid: got %0d want 1", nr); end
    checks++;
    if (cap !== E0) begin failures++; $display("FAIL stale_product: got %h want %h", cap, E0); end
    repeat (4) @(negedge Clock);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL stale_idle: got %b want 0", busy); end
    use_manual = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nr = 0;
    logic got_gnt = 1'b0;
    logic [71:0] cap = '0;
    do_reset();
    use_manual = 1'b1; manual_done = 1'b0;
    a0 = A0; b0 = B0; req0 = 1'b1;
    for (int c = 0; c < 10 && !got_gnt; c++) begin
      @(negedge Clock);
      if (gnt0) begin got_gnt = 1'b1; req0 = 1'b0; end
    end
    req0 = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (mm_enable !== 1'b1) begin failures++; $display("FAIL midrst_running: got %b want 1", mm_enable); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy, mm_enable, err} !== 7'b0 || {c_out, mm_a, mm_b} !== 216'h0) begin
      failures++;
      $display("FAIL midrst_outputs: got ctl=%b a=%h want 0", {gnt0, gnt1, rvalid0, rvalid1, busy, mm_enable, err}, mm_a);
    end
    manual_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      if (rvalid0 || rvalid1) nr++;
    end
    reset = 1'b1;
    manual_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      if (rvalid0 || rvalid1) nr++;
    end
    checks++;
    if (nr != 0) begin failures++; $display("FAIL midrst_no_rvalid: got %0d want 0", nr); end
    use_manual = 1'b0;
    req0 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (gnt0) req0 = 1'b0;
      if (rvalid0) begin nr++; cap = c_out; end
    end
    req0 = 1'b0;
    checks++;
    if (nr != 1 || cap !== E0) begin
      failures++; $display("FAIL midrst_recover: got n=%0d c=%h want n=1 c=%h", nr, cap, E0);
    end
  endtask

`ifdef MATMUL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int tg = -1, tr = -1;
    logic [71:0] cap = '1;
    logic err_at = 1'b0;
    do_reset();
    use_manual = 1'b1; manual_done = 1'b0;
    a0 = A0; b0 = B0; req0 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (gnt0) begin tg = c; req0 = 1'b0; end
      if (rvalid0) begin tr = c; cap = c_out; err_at = err; end
    end
    checks++;
    if (tr < 0 || tg < 0 || tr - tg < TO || tr - tg > TO + 2) begin
      failures++; $display("FAIL timeout_rvalid: got lag %0d want %0d..%0d", tr - tg, TO, TO + 2);
    end
    checks++;
    if (cap !== 72'h0 || err_at !== 1'b1) begin
      failures++; $display("FAIL timeout_result: got c=%h err=%b want 0 and 1", cap, err_at);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_sticky: got err=%b busy=%b want 1 0", err, busy);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_back_to_back();
    test_stale_done();
    test_reset_mid();
`ifdef MATMUL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
